// File: rtl/cdc_clear_sequencer.sv
// One side of a two-sided clear sequence (ISOLATE -> CLEAR -> POST_CLEAR).
// Phase requests and acks travel to and from the peer over a pair of 4-phase CDC channels.
module cdc_clear_sequencer #(
    parameter int unsigned CLEAR_CYCLES   = 3,
    parameter bit          START_ON_RESET = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       isolate_o,
    input  logic       isolate_ack_i,
    output logic       clear_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [2:0] tx_msg_o,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    input  logic [2:0] rx_msg_i
);
    localparam int unsigned    CntW   = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CLEAR_CYCLES);

    typedef enum logic [1:0] {
        PhIdle    = 2'd0,
        PhIsolate = 2'd1,
        PhClear   = 2'd2,
        PhPost    = 2'd3
    } phase_e;

    phase_e            r_cur, w_cur_d;
    phase_e            r_slot_ph, w_slot_ph_d;
    logic              r_init, w_init_d;
    logic              r_req_sent, w_req_sent_d;
    logic              r_ack_rcv, w_ack_rcv_d;
    logic              r_resp_pend, w_resp_pend_d;
    logic              r_slot_full, w_slot_full_d;
    logic              r_done, w_done_d;
    logic              r_first;
    logic              r_tx_lock, r_lock_ack;
    logic [CntW-1:0]   r_cnt, w_cnt_d;

    logic       w_complete, w_rx_fire, w_req_acc, w_ack_acc, w_load_ack;
    logic       w_start, w_adv, w_req_pend, w_sel_ack, w_tx_fire;
    logic [1:0] w_rx_ph;

    always_comb begin
        w_complete = 1'b0;
        case (r_cur)
            PhIsolate: w_complete = isolate_ack_i;
            PhClear:   w_complete = (r_cnt == CntMax);
            PhPost:    w_complete = 1'b1;
            default:   w_complete = 1'b0;
        endcase
    end

    assign w_rx_ph    = rx_msg_i[1:0];
    assign w_rx_fire  = rx_valid_i && !r_slot_full;
    // A req for the phase we already initiated counts as a responder request.
    assign w_req_acc  = w_rx_fire && !rx_msg_i[2] && (w_rx_ph != 2'd0) &&
                        ((r_cur == (w_rx_ph - 2'd1)) || (r_init && (r_cur == w_rx_ph)));
    assign w_ack_acc  = w_rx_fire && rx_msg_i[2] && r_init && (r_cur != PhIdle) &&
                        (r_cur == w_rx_ph);
    assign w_load_ack = r_resp_pend && !r_slot_full && w_complete;
    assign w_start    = (r_cur == PhIdle) && (clear_i || (START_ON_RESET && r_first));
    assign w_adv      = r_init && r_req_sent && r_ack_rcv && !r_resp_pend && w_complete &&
                        !w_req_acc;

    // Owed acks go out before our own req; a req already on the wire is held until taken.
    assign w_req_pend = r_init && (r_cur != PhIdle) && !r_req_sent &&
                        (!r_resp_pend || (r_tx_lock && !r_lock_ack));
    assign w_sel_ack  = r_tx_lock ? r_lock_ack : r_slot_full;
    assign w_tx_fire  = tx_valid_o && tx_ready_i;

    assign tx_valid_o = r_slot_full || w_req_pend;
    assign tx_msg_o   = w_sel_ack ? {1'b1, r_slot_ph} : {1'b0, r_cur};
    assign rx_ready_o = !r_slot_full;
    assign isolate_o  = (r_cur == PhIsolate) || (r_cur == PhClear);
    assign clear_o    = (r_cur == PhClear) && (r_cnt < CntMax);
    assign busy_o     = (r_cur != PhIdle);
    assign done_o     = r_done;

    always_comb begin
        w_cur_d       = r_cur;
        w_init_d      = r_init;
        w_req_sent_d  = r_req_sent;
        w_ack_rcv_d   = r_ack_rcv;
        w_resp_pend_d = r_resp_pend;
        w_slot_full_d = r_slot_full;
        w_slot_ph_d   = r_slot_ph;
        w_done_d      = 1'b0;
        w_cnt_d       = r_cnt;

        if (w_tx_fire) begin
            if (w_sel_ack) w_slot_full_d = 1'b0;
            else           w_req_sent_d  = 1'b1;
        end
        if (w_ack_acc) w_ack_rcv_d = 1'b1;
        if (w_load_ack) begin
            w_slot_full_d = 1'b1;
            w_slot_ph_d   = r_cur;
            w_resp_pend_d = 1'b0;
            if (!r_init && (r_cur == PhPost)) w_cur_d = PhIdle;
        end
        if (w_start) begin
            w_init_d = 1'b1;
            w_cur_d  = PhIsolate;
        end
        if (w_adv) begin
            case (r_cur)
                PhIsolate: w_cur_d = PhClear;
                PhClear:   w_cur_d = PhPost;
                default: begin
                    w_cur_d  = PhIdle;
                    w_init_d = 1'b0;
                    w_done_d = 1'b1;
                end
            endcase
        end
        if (w_req_acc) begin
            w_cur_d       = phase_e'(w_rx_ph);
            w_resp_pend_d = 1'b1;
        end
        if (w_cur_d != r_cur) begin
            w_req_sent_d = 1'b0;
            w_ack_rcv_d  = 1'b0;
        end

        if ((w_cur_d == PhClear) && (r_cur != PhClear)) begin
            w_cnt_d = '0;
        end else if ((r_cur == PhClear) && (r_cnt != CntMax)) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cur       <= PhIdle;
            r_init      <= 1'b0;
            r_req_sent  <= 1'b0;
            r_ack_rcv   <= 1'b0;
            r_resp_pend <= 1'b0;
            r_slot_full <= 1'b0;
            r_slot_ph   <= PhIdle;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_first     <= 1'b1;
            r_tx_lock   <= 1'b0;
            r_lock_ack  <= 1'b0;
        end else begin
            r_cur       <= w_cur_d;
            r_init      <= w_init_d;
            r_req_sent  <= w_req_sent_d;
            r_ack_rcv   <= w_ack_rcv_d;
            r_resp_pend <= w_resp_pend_d;
            r_slot_full <= w_slot_full_d;
            r_slot_ph   <= w_slot_ph_d;
            r_done      <= w_done_d;
            r_cnt       <= w_cnt_d;
            r_first     <= 1'b0;
            r_tx_lock   <= tx_valid_o && !tx_ready_i;
            r_lock_ack  <= w_sel_ack;
        end
    end
endmodule
